// File: rtl/ram_write_ctrl_pkg.sv
// Shared types for the RAM write-side controller.
package ram_write_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } ram_wr_state_t;

endpackage

// File: rtl/ram_write_ctrl_wrap_counter.sv
// Modulo-DEPTH address pointer: loads a (reduced) start address, then
// advances by one with wrap from DEPTH-1 back to 0.
module wrap_counter #(
  parameter int ADDRESSWIDTH = 6,
  parameter int DEPTH        = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [ADDRESSWIDTH-1:0] load_val,
  input  logic                    inc,
  output logic [ADDRESSWIDTH-1:0] ptr
);

  localparam bit                    POW2    = (DEPTH == (1 << ADDRESSWIDTH));
  localparam logic [ADDRESSWIDTH-1:0] LAST    = ADDRESSWIDTH'(DEPTH - 1);
  // Divisor forced non-zero when DEPTH fills the whole address space.
  localparam logic [ADDRESSWIDTH-1:0] DEPTH_A = ADDRESSWIDTH'(POW2 ? 1 : DEPTH);

  logic [ADDRESSWIDTH-1:0] ptr_d, ptr_q;
  logic [ADDRESSWIDTH-1:0] load_mod;

  always_comb begin
    load_mod = POW2 ? load_val : (load_val % DEPTH_A);
    ptr_d    = ptr_q;
    if (load) begin
      ptr_d = load_mod;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_write_ctrl.sv
// Write-side controller for the project block RAM: bulk clear, stream load
// with address wrap, and idle read-address forwarding.
// Optional checksum output enabled by defining RAM_WRITE_CTRL_CHECKSUM_EN.
module ram_write_ctrl
  import ram_write_ctrl_pkg::*;
#(
  parameter int                   ADDRESSWIDTH = 6,
  parameter int                   BITWIDTH     = 10,
  parameter int                   DEPTH        = 34,
  parameter logic [BITWIDTH-1:0]  CLEAR_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  input  logic                    load_req,
  input  logic [ADDRESSWIDTH-1:0] load_base,
  input  logic [ADDRESSWIDTH:0]   load_len,
  input  logic                    s_valid,
  input  logic [BITWIDTH-1:0]     s_data,
  output logic                    s_ready,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic                    ram_we,
  output logic [ADDRESSWIDTH-1:0] ram_a,
  output logic [BITWIDTH-1:0]     ram_din,
  output logic                    busy,
  output logic                    done,
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
  output logic [BITWIDTH-1:0]     checksum,
`endif
  output logic                    err
);

  localparam logic [ADDRESSWIDTH:0] DEPTH_L = (ADDRESSWIDTH+1)'(DEPTH);
  localparam logic [ADDRESSWIDTH:0] CNT_ONE = (ADDRESSWIDTH+1)'(1);

  ram_wr_state_t           state_d, state_q;
  logic [ADDRESSWIDTH:0]   cnt_d, cnt_q;
  logic                    err_d, err_q;
  logic                    ptr_load, ptr_inc;
  logic [ADDRESSWIDTH-1:0] ptr_load_val;
  logic [ADDRESSWIDTH-1:0] wr_ptr;
  logic                    len_ok;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
  logic [BITWIDTH-1:0]     csum_d, csum_q;
`endif

  wrap_counter #(
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .DEPTH        (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ptr_load),
    .load_val (ptr_load_val),
    .inc      (ptr_inc),
    .ptr      (wr_ptr)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    ptr_load     = 1'b0;
    ptr_load_val = load_base;
    ptr_inc      = 1'b0;
    s_ready      = 1'b0;
    ram_we       = 1'b0;
    ram_a        = rd_addr;
    ram_din      = s_data;
    busy         = 1'b0;
    done         = 1'b0;
    len_ok       = (load_len != '0) && (load_len <= DEPTH_L);
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Clear has priority; a simultaneous load is dropped silently.
        if (clear_req) begin
          state_d      = CLEAR;
          ptr_load     = 1'b1;
          ptr_load_val = '0;
          cnt_d        = DEPTH_L;
        end else if (load_req) begin
          if (len_ok) begin
            state_d  = LOAD;
            ptr_load = 1'b1;
            cnt_d    = load_len;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
            csum_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        ram_we  = 1'b1;
        ram_a   = wr_ptr;
        ram_din = CLEAR_VALUE;
        ptr_inc = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        ram_a   = wr_ptr;
        if (s_valid) begin
          ram_we  = 1'b1;
          ptr_inc = 1'b1;
          cnt_d   = cnt_q - 1'b1;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
          csum_d  = csum_q ^ s_data;
`endif
          if (cnt_q == CNT_ONE) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign err = err_q;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Scoreboard bench for ram_write_ctrl: stimulus tasks push expected RAM
// writes; a negedge monitor pops and compares every write the DUT issues.
module tb_ram_write_ctrl;

  localparam int AW = 6;
  localparam int BW = 10;
  localparam int D  = 34;
  localparam logic [BW-1:0] CV = 10'h155;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req, load_req;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic [BW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] rd_addr;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [BW-1:0] ram_din;
  logic          busy, done, err;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
  logic [BW-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0, err_seen = 0;
  int exp_done = 0, exp_err = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [BW-1:0] ref_mem [D];

  // Behavioural RAM with registered read address, as the real RAM has.
  logic [BW-1:0] ram_mem [64];
  logic [AW-1:0] rd_lat;
  logic [BW-1:0] ram_dout;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_din;
    rd_lat <= ram_a;
  end
  assign ram_dout = ram_mem[rd_lat];

  ram_write_ctrl #(
    .ADDRESSWIDTH (AW),
    .BITWIDTH     (BW),
    .DEPTH        (D),
    .CLEAR_VALUE  (CV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .load_req  (load_req),
    .load_base (load_base),
    .load_len  (load_len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .rd_addr   (rd_addr),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_din   (ram_din),
    .busy      (busy),
    .done      (done),
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .err       (err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT write must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (done === 1'b1) done_seen++;
      if (err === 1'b1) err_seen++;
      if (ram_we !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", ram_a, ram_din);
        end else begin
          mon_e = exp_q.pop_front();
          if (ram_a !== mon_e.a || ram_din !== mon_e.d) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     ram_a, ram_din, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input bit with_load, input bit disturb);
    int  c0;
    int  dcyc = 0;
    bit  got = 1'b0;
    clear_req = 1'b1;
    if (with_load) begin
      load_req  = 1'b1;
      load_base = 6'd3;
      load_len  = 7'd4;
    end
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(wr_t'{a: AW'(i), d: CV});
      ref_mem[i] = CV;
    end
    exp_done++;
    c0 = cyc + 1;
    tick();
    clear_req = 1'b0;
    load_req  = 1'b0;
    if (disturb) begin
      s_valid = 1'b1;
      s_data  = BW'($urandom);
    end
    for (int n = 0; n < D + 10; n++) begin
      @(negedge clk);
      if (disturb && n == 4) chk("s_ready_in_clear", 32'(s_ready), 32'd0);
      if (disturb && n == 5) begin
        load_req = 1'b1;
        load_len = 7'd0;
      end
      if (disturb && n == 6) load_req = 1'b0;
      if (done === 1'b1) begin
        got  = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    s_valid = 1'b0;
    chk("clear_done_seen", 32'(got), 32'd1);
    chk("clear_done_latency", 32'(dcyc - c0), 32'(D));
    tick();
    chk("clear_idle_busy", 32'(busy), 32'd0);
    chk("clear_idle_done", 32'(done), 32'd0);
  endtask

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
  task automatic do_load(input int base, input int len, input int mode, input bit seq, input int abort);
    logic [BW-1:0] words[$];
    int b, i, budget;
    bit v;
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    logic [BW-1:0] cs = '0;
`endif
    load_base = AW'(base);
    load_len  = (AW+1)'(len);
    load_req  = 1'b1;
    if (len == 0 || len > D) begin
      exp_err++;
      tick();
      load_req = 1'b0;
      repeat (2) tick();
      chk("rejected_busy", 32'(busy), 32'd0);
      chk("rejected_s_ready", 32'(s_ready), 32'd0);
      return;
    end
    b = base % D;
    for (int k = 0; k < len; k++) begin
      words.push_back(seq ? BW'(k + 1) : BW'($urandom));
      exp_q.push_back(wr_t'{a: AW'((b + k) % D), d: words[k]});
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
      cs = cs ^ words[k];
`endif
    end
    if (abort == 0) exp_done++;
    tick();
    load_req = 1'b0;
    i = 0;
    budget = 0;
    while (i < len && budget < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 1) == 1);
      s_valid = v;
      s_data  = v ? words[i] : BW'($urandom);
      @(negedge clk);
      chk("s_ready_in_load", 32'(s_ready), 32'd1);
      if (v) begin
        ref_mem[(b + i) % D] = words[i];
        i++;
      end
      tick();
      budget++;
      if (abort != 0 && i == abort) break;
    end
    s_valid = 1'b0;
    if (abort != 0) return;
    chk("load_words_accepted", 32'(i), 32'(len));
    @(negedge clk);
    chk("load_done_after_last", 32'(done), 32'd1);
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(cs));
`endif
    tick();
    chk("load_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic readback(input int a);
    rd_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    chk("readback", 32'(ram_dout), 32'(ref_mem[a]));
  endtask

  initial begin
    rst_n     = 1'b0;
    clear_req = 1'b0;
    load_req  = 1'b0;
    load_base = '0;
    load_len  = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    rd_addr   = 6'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_ram_a", 32'(ram_a), 32'd7);
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    chk("reset_checksum", 32'(checksum), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    do_clear(1'b0, 1'b0);
    do_load(30, 6, 0, 1'b1, 0);
    do_load(30, 6, 1, 1'b1, 0);
    do_load(0, 0, 0, 1'b0, 0);
    do_load(0, 35, 0, 1'b0, 0);
    do_load(40, 5, 0, 1'b0, 0);
    do_clear(1'b1, 1'b1);

    // Reset in the middle of a 10-word load, right after the third write.
    do_load(5, 10, 0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ram_a", 32'(ram_a), 32'(rd_addr));
`ifdef RAM_WRITE_CTRL_CHECKSUM_EN
    chk("abort_checksum", 32'(checksum), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    for (int a = 5; a < 9; a++) readback(a);
    do_clear(1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 5) == 0) do_clear(1'b0, 1'b0);
      else do_load($urandom_range(0, 63), $urandom_range(0, 38), 2, 1'b0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    for (int a = 0; a < D; a++) readback(a);
    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(exp_done));
    chk("err_count", 32'(err_seen), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
